quad_decoder: RTL and testbench

Quadrature decoder for the two-phase A/B signal pair used by the stepper test rig. It is the receive-side counterpart of the phase generator that drives the motor outputs. It synchronises and deglitches raw A/B lines from the header, then decodes Gray-code transitions into a signed position count, step pulses and direction. It also produces a windowed velocity measurement. It is used both for encoder feedback and for loopback checking of the phase generator.

---
 rtl/quad_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_quad_decoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quad_decoder
// Purpose  : Deglitched A/B quadrature decoder giving position, step, direction
//            and sticky error; windowed velocity is built when QDEC_VEL_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
module quad_decoder #(
    parameter int CNT_W    = 32,
    parameter int FILT_LEN = 4,
    parameter int VEL_WIN  = 50000
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             PH_A,
    input  logic             PH_B,
    input  logic             CLR,
    input  logic             ERR_CLR,
    output logic [CNT_W-1:0] POS,
    output logic             STEP,
    output logic             DIR,
    output logic             ERR,
    output logic [15:0]      VEL,
    output logic             VEL_VALID
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] c_FILT_LAST = 4'(FILT_LEN - 1);

    state_t     r_state_q, w_state_d;
    logic [1:0] r_init_cnt_q, w_init_cnt_d;
    logic       w_init_load;
    logic       w_run;

    always_comb begin
        w_state_d    = r_state_q;
        w_init_cnt_d = r_init_cnt_q;
        w_init_load  = 1'b0;
        case (r_state_q)
            ST_INIT: begin
                if (r_init_cnt_q == 2'd2) begin
                    w_init_load = 1'b1;
                    w_state_d   = ST_RUN;
                end else begin
                    w_init_cnt_d = r_init_cnt_q + 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state_q    <= ST_INIT;
            r_init_cnt_q <= 2'd0;
        end else begin
            r_state_q    <= w_state_d;
            r_init_cnt_q <= w_init_cnt_d;
        end
    end

    assign w_run = (r_state_q == ST_RUN);

    // Bit 1 carries phase A, bit 0 phase B, matching the {A,B} Gray ordering.
    logic [1:0] w_ph_raw;
    logic [1:0] w_s2;
    logic [1:0] w_f;
    assign w_ph_raw = {PH_A, PH_B};

    for (genvar gi = 0; gi < 2; gi++) begin : g_phase
        logic       r_s1_q;
        logic       r_s2_q;
        logic       r_f_q, w_f_d;
        logic [3:0] r_cnt_q, w_cnt_d;

        always_comb begin
            w_f_d   = r_f_q;
            w_cnt_d = 4'd0;
            if (w_init_load) begin
                w_f_d = r_s2_q;
            end else if (w_run && (r_s2_q != r_f_q)) begin
                if (r_cnt_q == c_FILT_LAST) begin
                    w_f_d = r_s2_q;
                end else begin
                    w_cnt_d = r_cnt_q + 4'd1;
                end
            end
        end

        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                r_s1_q  <= 1'b0;
                r_s2_q  <= 1'b0;
                r_f_q   <= 1'b0;
                r_cnt_q <= 4'd0;
            end else begin
                r_s1_q  <= w_ph_raw[gi];
                r_s2_q  <= r_s1_q;
                r_f_q   <= w_f_d;
                r_cnt_q <= w_cnt_d;
            end
        end

        assign w_s2[gi] = r_s2_q;
        assign w_f[gi]  = r_f_q;
    end

    // Gray position along the forward cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    logic [1:0]       r_prev_q, w_prev_d;
    logic [1:0]       w_diff;
    logic             w_fwd, w_rev, w_bad;
    logic [CNT_W-1:0] r_pos_q, w_pos_d;
    logic             r_step_q, w_step_d;
    logic             r_dir_q, w_dir_d;
    logic             r_err_q, w_err_d;

    always_comb begin
        w_diff   = gray_idx(w_f) - gray_idx(r_prev_q);
        w_fwd    = w_run && (w_diff == 2'd1);
        w_rev    = w_run && (w_diff == 2'd3);
        w_bad    = w_run && (w_diff == 2'd2);
        w_prev_d = r_prev_q;
        if (w_init_load) begin
            w_prev_d = w_s2;
        end else if (w_run) begin
            w_prev_d = w_f;
        end
        // A reverse step adds all ones, i.e. -1 modulo 2^CNT_W.
        w_pos_d  = CLR ? '0 : r_pos_q + {{(CNT_W-1){w_rev}}, w_fwd | w_rev};
        w_step_d = w_fwd | w_rev;
        w_dir_d  = w_fwd ? 1'b1 : (w_rev ? 1'b0 : r_dir_q);
        w_err_d  = w_bad | (r_err_q & ~ERR_CLR);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_prev_q <= 2'b00;
            r_pos_q  <= '0;
            r_step_q <= 1'b0;
            r_dir_q  <= 1'b0;
            r_err_q  <= 1'b0;
        end else begin
            r_prev_q <= w_prev_d;
            r_pos_q  <= w_pos_d;
            r_step_q <= w_step_d;
            r_dir_q  <= w_dir_d;
            r_err_q  <= w_err_d;
        end
    end

    assign POS  = r_pos_q;
    assign STEP = r_step_q;
    assign DIR  = r_dir_q;
    assign ERR  = r_err_q;

    // Out-of-range parameters leave this marker block in the elaborated tree.
    if (VEL_WIN < 2 || FILT_LEN < 2 || FILT_LEN > 15) begin : g_param_out_of_range
    end

`ifdef QDEC_VEL_EN
    localparam int                 c_WIN_W    = $clog2(VEL_WIN);
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(VEL_WIN - 1);

    function automatic logic [15:0] sat16(input logic [16:0] s);
        if (s[16] != s[15]) begin
            return s[16] ? 16'h8000 : 16'h7FFF;
        end
        return s[15:0];
    endfunction

    logic [c_WIN_W-1:0] r_win_q, w_win_d;
    logic [15:0]        r_acc_q, w_acc_d;
    logic [15:0]        r_vel_q, w_vel_d;
    logic               r_vel_valid_q, w_vel_valid_d;
    logic [16:0]        w_acc_sum;

    always_comb begin
        w_acc_sum     = {r_acc_q[15], r_acc_q} + {{16{w_rev}}, w_fwd | w_rev};
        w_win_d       = r_win_q + c_WIN_W'(1);
        w_acc_d       = sat16(w_acc_sum);
        w_vel_d       = r_vel_q;
        w_vel_valid_d = 1'b0;
        if (r_win_q == c_WIN_LAST) begin
            w_win_d       = '0;
            w_acc_d       = 16'd0;
            w_vel_d       = sat16(w_acc_sum);
            w_vel_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_win_q       <= '0;
            r_acc_q       <= 16'd0;
            r_vel_q       <= 16'd0;
            r_vel_valid_q <= 1'b0;
        end else begin
            r_win_q       <= w_win_d;
            r_acc_q       <= w_acc_d;
            r_vel_q       <= w_vel_d;
            r_vel_valid_q <= w_vel_valid_d;
        end
    end

    assign VEL       = r_vel_q;
    assign VEL_VALID = r_vel_valid_q;
`else
    assign VEL       = 16'd0;
    assign VEL_VALID = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_decoder
// Purpose  : Directed scoreboard bench for quad_decoder (CNT_W=8 so wrap is
//            reachable); velocity expectations follow QDEC_VEL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_decoder;

    localparam int CNT_W    = 8;
    localparam int FILT_LEN = 4;
    localparam int VEL_WIN  = 100;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ph_a, ph_b, clr, err_clr;
    logic [CNT_W-1:0] pos;
    logic             step, dir, err;
    logic [15:0]      vel;
    logic             vel_valid;

    quad_decoder #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .VEL_WIN(VEL_WIN)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .PH_A     (ph_a),
        .PH_B     (ph_b),
        .CLR      (clr),
        .ERR_CLR  (err_clr),
        .POS      (pos),
        .STEP     (step),
        .DIR      (dir),
        .ERR      (err),
        .VEL      (vel),
        .VEL_VALID(vel_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] pos;
        logic             dir;
        int               cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         vv_cyc[$];
    logic [15:0] vv_val[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_steps = 0;
    int         n_pushed = 0;
    int         n_valid = 0;
    logic       step_prev = 1'b0;
    logic [1:0] m_ab;
    logic [CNT_W-1:0] m_pos;
    logic       m_dir;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev_next(input logic [1:0] ab);
        return fwd_next(fwd_next(fwd_next(ab)));
    endfunction

    // Output monitor: every STEP pops one expected transition.
    always @(negedge clk) begin
        if (!rst_n) begin
            step_prev = 1'b0;
        end else begin
            if (vel_valid) begin
                n_valid++;
                vv_cyc.push_back(cyc);
                vv_val.push_back(vel);
            end
            if (step) begin
                exp_t e;
                n_steps++;
                check("step_one_cycle", {31'd0, step_prev}, 32'd0);
                n_cmp++;
                assert (sb_q.size() != 0) else begin
                    n_bad++;
                    $error("FAIL unexpected_step: observed STEP at cycle %0d expected no step", cyc);
                end
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("step_pos", {24'd0, pos}, {24'd0, e.pos});
                    check("step_dir", {31'd0, dir}, {31'd0, e.dir});
                    check("step_latency", cyc, e.cyc);
                end
            end
            step_prev = step;
        end
    end

    // Drives a new {A,B} level and records the decode the model expects.
    task automatic drive_ab(input logic [1:0] ab, input int gap, input bit clr_hit);
        exp_t e;
        {ph_a, ph_b} = ab;
        if (ab == fwd_next(m_ab) || m_ab == fwd_next(ab)) begin
            if (ab == fwd_next(m_ab)) begin
                m_pos = m_pos + 1'b1;
                m_dir = 1'b1;
            end else begin
                m_pos = m_pos - 1'b1;
                m_dir = 1'b0;
            end
            if (clr_hit) m_pos = '0;
            e.pos = m_pos;
            e.dir = m_dir;
            e.cyc = cyc + FILT_LEN + 3;
            sb_q.push_back(e);
            n_pushed++;
        end
        m_ab = ab;
        if (clr_hit) begin
            repeat (FILT_LEN + 2) @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            repeat (gap - FILT_LEN - 3) @(negedge clk);
        end else begin
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_pos = '0;
        @(negedge clk);
    endtask

    initial begin
        int t0;
        int found;
        int last_p;
        {ph_a, ph_b} = 2'b11;
        clr = 1'b0;
        err_clr = 1'b0;
        rst_n = 1'b0;
        m_ab = 2'b11;
        m_pos = '0;
        m_dir = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_pos", {24'd0, pos}, 32'd0);
        check("rst_step", {31'd0, step}, 32'd0);
        check("rst_dir", {31'd0, dir}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_vel", {16'd0, vel}, 32'd0);
        check("rst_vel_valid", {31'd0, vel_valid}, 32'd0);

        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("init_pos", {24'd0, pos}, 32'd0);
        check("init_err", {31'd0, err}, 32'd0);
        check("init_no_step", n_steps, 0);

        // Eight forward transitions starting from 11.
        for (int i = 0; i < 8; i++) drive_ab(fwd_next(m_ab), 20, 1'b0);
        check("fwd8_pos", {24'd0, pos}, 32'd8);
        check("fwd8_dir", {31'd0, dir}, 32'd1);
        check("fwd8_steps", n_steps, 8);

        for (int i = 0; i < 3; i++) drive_ab(rev_next(m_ab), 20, 1'b0);
        check("rev3_pos", {24'd0, pos}, 32'd5);
        check("rev3_dir", {31'd0, dir}, 32'd0);

        // 3-cycle glitch on A is filtered out.
        ph_a = ~ph_a;
        repeat (FILT_LEN - 1) @(negedge clk);
        ph_a = ~ph_a;
        repeat (20) @(negedge clk);
        check("glitch_pos", {24'd0, pos}, 32'd5);
        check("glitch_steps", n_steps, 11);

        // 4-cycle pulse on A passes: one step each way.
        drive_ab({~m_ab[1], m_ab[0]}, FILT_LEN, 1'b0);
        drive_ab({~m_ab[1], m_ab[0]}, 20, 1'b0);
        check("pulse4_pos", {24'd0, pos}, 32'd5);
        check("pulse4_steps", n_steps, 13);

        drive_ab(fwd_next(m_ab), 20, 1'b0);
        check("to00_ab", {30'd0, m_ab}, 32'd0);
        drive_ab(2'b11, 20, 1'b0);
        check("err_set", {31'd0, err}, 32'd1);
        check("err_pos", {24'd0, pos}, 32'd6);
        check("err_dir_hold", {31'd0, dir}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr", {31'd0, err}, 32'd0);

        // New error on the same edge as ERR_CLR keeps ERR set.
        drive_ab(2'b00, FILT_LEN + 2, 1'b0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("err_vs_clr", {31'd0, err}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr2", {31'd0, err}, 32'd0);

        pulse_clr();
        check("clr_pos", {24'd0, pos}, 32'd0);
        for (int i = 0; i < 127; i++) drive_ab(fwd_next(m_ab), FILT_LEN + 2, 1'b0);
        repeat (10) @(negedge clk);
        check("pos_max", {24'd0, pos}, 32'h7F);
        drive_ab(fwd_next(m_ab), 12, 1'b0);
        check("pos_wrap_up", {24'd0, pos}, 32'h80);
        pulse_clr();
        drive_ab(rev_next(m_ab), 12, 1'b0);
        check("pos_wrap_down", {24'd0, pos}, 32'hFF);

        drive_ab(fwd_next(m_ab), 20, 1'b1);
        check("clr_wins_pos", {24'd0, pos}, 32'd0);
        check("clr_wins_dir", {31'd0, dir}, 32'd1);

        // Steady forward stepping every 10 cycles for the velocity window.
        t0 = cyc;
        for (int i = 0; i < 40; i++) drive_ab(fwd_next(m_ab), 10, 1'b0);
        repeat (10) @(negedge clk);
`ifdef QDEC_VEL_EN
        found = 0;
        last_p = -1;
        for (int i = 0; i < vv_cyc.size(); i++) begin
            if (vv_cyc[i] >= t0 + 110 && vv_cyc[i] <= t0 + 397) begin
                check("vel_value", {16'd0, vv_val[i]}, 32'd10);
                if (last_p >= 0) check("vel_period", vv_cyc[i] - last_p, VEL_WIN);
                found++;
            end
            last_p = vv_cyc[i];
        end
        check("vel_pulses_seen", {31'd0, found >= 2}, 32'd1);
`else
        found = t0;
        last_p = found;
        check("vel_never_valid", n_valid, 0);
        check("vel_zero", {16'd0, vel}, 32'd0);
`endif

        // Asynchronous reset mid-operation clears outputs without a clock edge.
        check("pre_rst_pos", {24'd0, pos}, 32'd40);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pos", {24'd0, pos}, 32'd0);
        check("async_rst_dir", {31'd0, dir}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_pos = '0;
        repeat (15) @(negedge clk);
        check("post_rst_pos", {24'd0, pos}, 32'd0);
        check("pending_steps", sb_q.size(), 0);
        check("total_steps", n_steps, n_pushed);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
